scan_sel_seq_4ch: RTL and testbench
===================================

// Module: scan_sel_seq_4ch
// PURPOSE
//  Upstream sequencer for the 2-to-4 one-hot decoder.
//  - Steps a 2-bit channel index `sel` through the enabled channels of a 4-bit mask.
//  - Holds each channel for a programmable dwell time.
//  - Typical use: multiplexed display or peripheral scan, where `sel` drives the decoder
//    and `valid` gates the decoded one-hot enables.
// PARAMETERS
//  DWELL_W  8  width of dwell count; max hold per channel = 2**DWELL_W cycles
// PORTS
//  clk     in   1        single clock, rising edge
//  rst     in   1        synchronous, active-high reset
//  start   in   1        pulse: begin a scan (sampled only in IDLE)
//  stop    in   1        pulse: abort scan (sampled in IDLE and SCAN)
//  cont    in   1        latched at start: 1=continuous wrap, 0=single pass
//  ch_en   in   4        channel mask, latched at start; bit i enables channel i
//  dwell   in   DWELL_W  latched at start; each channel held dwell+1 cycles
//  sel     out  2        current channel index (to decoder d input)
//  valid   out  1        sel is meaningful; decoder output may be used
//  busy    out  1        high in SCAN
//  ch_adv  out  1        1-cycle pulse on the cycle sel changes to a new channel
//  done    out  1        1-cycle pulse on scan termination
// BEHAVIOUR
//  Reset (rst=1 at clock edge)
//  - State=IDLE; sel=0, valid=0, busy=0, ch_adv=0, done=0.
//  - Latched mask, dwell and cont cleared; dwell counter=0.
//  - Reset mid-scan aborts with no done pulse.
//  FSM: IDLE, SCAN
//  - All outputs are registered.
//  IDLE
//  - start=1, stop=0, ch_en!=0:
//    - latch ch_en, dwell, cont; load counter=dwell.
//    - next cycle: SCAN, valid=1, busy=1, sel=lowest set bit of ch_en. No ch_adv pulse for the first channel.
//  - start=1, ch_en==0: done=1 for 1 cycle; stay IDLE; valid stays 0.
//  - start=1 and stop=1 same cycle: stop wins; nothing happens, no done.
//  SCAN
//  - Counter decrements each cycle while >0.
//  - Counter==0 at a clock edge: advance sel to the next enabled channel in ascending order,
//    wrapping 3->0. Reload counter=dwell; ch_adv=1 next cycle.
//  - Single pass (cont=0):
//    - When the highest enabled channel's dwell expires: IDLE; next cycle valid=0, busy=0, done=1.
//    - sel keeps its last value.
//  - Continuous (cont=1): after the highest enabled channel, wrap to the lowest enabled channel.
//    Never self-terminates.
//  - Single enabled channel, cont=1: sel constant; counter reloads; ch_adv pulses on each reload.
//  - stop=1: IDLE next cycle; valid=0, busy=0, done=1. Takes precedence over an advance in the same cycle.
//  - start in SCAN is ignored.
//  - ch_en, dwell and cont changes during SCAN are ignored (latched copies are used).
//  Timing
//  - start sampled at edge N -> valid=1 at N+1.
//  - Each channel is visible for exactly dwell+1 cycles.
//  - dwell=0 -> new channel every cycle.
//  - Single pass total = k*(dwell+1) cycles of valid (k = popcount of ch_en), then done.
//  - done and ch_adv are never high together.
// CONFIGURATION
//  SCAN_HOLD_EN
//  - Defined: adds input port `hold` (1 bit, after stop).
//    - hold=1 in SCAN freezes the dwell counter and sel; valid stays 1; no advance.
//    - stop still aborts while hold=1; hold has no effect in IDLE.
//  - Undefined: port absent; counter always runs in SCAN.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> sel=0, valid=busy=ch_adv=done=0.
//  2. ch_en=4'b1111, dwell=2, cont=0, start -> sel 0,1,2,3 each valid 3 cycles (12 total);
//     ch_adv 3 times; done 1 cycle after; valid=0.
//  3. ch_en=4'b1010, dwell=0, cont=1, start -> sel 1,3,1,3 every cycle, no done;
//     stop at cycle 5 -> valid=0 and done=1 next cycle.
//  4. ch_en=4'b0000, start -> done=1 one cycle, valid=0 throughout;
//     start with stop in the same cycle -> no done, stays IDLE.
//  5. ch_en=4'b0100, dwell=3, cont=0 -> sel=2 for 4 cycles, no ch_adv, then done;
//     rst asserted mid-scan -> outputs reset values next cycle, no done.
//  6. SCAN_HOLD_EN defined: ch_en=4'b0011, dwell=1, hold=1 for 5 cycles during channel 0
//     -> sel=0 held 7 cycles, then sel=1 for 2 cycles, then done.

Source files
------------

// File: rtl/scan_sel_seq_4ch.sv
// ---------------------------------------------------------------------------
// scan_sel_seq_4ch
//   Upstream sequencer for a 2-to-4 one-hot decoder. It steps a 2-bit channel
//   index through the enabled channels of a 4-bit mask and holds each channel
//   for dwell+1 cycles. It can make a single pass or scan continuously.
//
//   Optional feature: define SCAN_HOLD_EN to add the i_hold input. While
//   i_hold=1 in SCAN, the dwell counter and sel freeze. i_stop still aborts.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      pulse: begin a scan (IDLE only)
//   i_stop       pulse: abort a scan; also suppresses i_start in IDLE
//   i_hold       (SCAN_HOLD_EN only) freeze counter and sel in SCAN
//   i_cont       latched at start: 1=continuous wrap, 0=single pass
//   i_ch_en      channel mask, latched at start
//   i_dwell      latched at start; each channel is held dwell+1 cycles
//   o_sel        current channel index
//   o_valid      o_sel is meaningful
//   o_busy       high while scanning
//   o_ch_adv     1-cycle pulse when o_sel moves to a new channel
//   o_done       1-cycle pulse on scan termination
//   o_dbg_state  current FSM state (0=IDLE, 1=SCAN) for checkers
//
// Handshake: none. i_start and i_stop are sampled on each rising edge.
// o_valid stays high for every cycle in which o_sel drives the decoder.
// ---------------------------------------------------------------------------
module scan_sel_seq_4ch #(
    parameter int DWELL_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
`ifdef SCAN_HOLD_EN
    input  logic               i_hold,
`endif
    input  logic               i_cont,
    input  logic [3:0]         i_ch_en,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [1:0]         o_sel,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_ch_adv,
    output logic               o_done,
    output logic               o_dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]         r_state;
    logic [3:0]         r_mask;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_cont;
    logic [DWELL_W-1:0] r_cnt;
    logic [1:0]         r_sel;
    logic               r_valid;
    logic               r_busy;
    logic               r_ch_adv;
    logic               r_done;

    logic               w_hold;
    logic [2:0]         w_nxt;

`ifdef SCAN_HOLD_EN
    assign w_hold = i_hold;
`else
    assign w_hold = 1'b0;
`endif

    // Return the index of the lowest set bit. An empty mask is never passed in.
    function automatic logic [1:0] lowest_en(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Return {found, index} for the lowest enabled channel strictly above cur.
    // found=0 means cur is the highest enabled channel in the mask.
    function automatic logic [2:0] next_above(input logic [3:0] m, input logic [1:0] cur);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(cur) && m[i]) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign w_nxt = next_above(r_mask, r_sel);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_mask   <= 4'd0;
            r_dwell  <= '0;
            r_cont   <= 1'b0;
            r_cnt    <= '0;
            r_sel    <= 2'd0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_ch_adv <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ch_adv <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_stop) begin
                        if (i_ch_en != 4'd0) begin
                            r_mask  <= i_ch_en;
                            r_dwell <= i_dwell;
                            r_cont  <= i_cont;
                            r_cnt   <= i_dwell;
                            r_sel   <= lowest_en(i_ch_en);
                            r_valid <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= ST_SCAN;
                        end else begin
                            // An empty mask finishes at once. The FSM stays in IDLE.
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (i_stop) begin
                        // Stop wins over an advance due in the same cycle. sel keeps its value.
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (!w_hold) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - DWELL_W'(1);
                        end else if (w_nxt[2]) begin
                            r_cnt    <= r_dwell;
                            r_sel    <= w_nxt[1:0];
                            r_ch_adv <= 1'b1;
                        end else if (r_cont) begin
                            // Wrap to the lowest channel. With one channel enabled,
                            // sel keeps the same value but ch_adv still pulses.
                            r_cnt    <= r_dwell;
                            r_sel    <= lowest_en(r_mask);
                            r_ch_adv <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sel       = r_sel;
    assign o_valid     = r_valid;
    assign o_busy      = r_busy;
    assign o_ch_adv    = r_ch_adv;
    assign o_done      = r_done;
    assign o_dbg_state = r_state[0];

endmodule

// File: tb/tb_scan_sel_seq_4ch.sv
// Testbench for scan_sel_seq_4ch. Each expected output cycle is written as
// {valid, busy, sel[1:0], ch_adv, done}. Every cycle in which the DUT shows
// any activity consumes one entry from exp_q.
module tb_scan_sel_seq_4ch;

  localparam int DWELL_W = 8;
  localparam int W = 6;

  logic               i_clk;
  logic               i_rst;
  logic               i_start;
  logic               i_stop;
  logic               i_hold;
  logic               i_cont;
  logic [3:0]         i_ch_en;
  logic [DWELL_W-1:0] i_dwell;
  logic [1:0]         o_sel;
  logic               o_valid;
  logic               o_busy;
  logic               o_ch_adv;
  logic               o_done;
  logic               o_dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  scan_sel_seq_4ch #(.DWELL_W(DWELL_W)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_stop(i_stop),
`ifdef SCAN_HOLD_EN
    .i_hold(i_hold),
`endif
    .i_cont(i_cont),
    .i_ch_en(i_ch_en),
    .i_dwell(i_dwell),
    .o_sel(o_sel),
    .o_valid(o_valid),
    .o_busy(o_busy),
    .o_ch_adv(o_ch_adv),
    .o_done(o_done),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [W-1:0] rec(input logic v, input logic b, input logic [1:0] s,
                                       input logic adv, input logic dn);
    return {v, b, s, adv, dn};
  endfunction

  // monitor / scoreboard
  always @(negedge i_clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (o_valid === 1'b1 || o_busy === 1'b1 || o_ch_adv === 1'b1 || o_done === 1'b1) begin
      act = {o_valid, o_busy, o_sel, o_ch_adv, o_done};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected t=%0t act{v,b,sel,adv,done}=%b exp=<none>", $time, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL out_rec t=%0t act{v,b,sel,adv,done}=%b exp=%b", $time, act, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic do_start(input logic [3:0] en, input logic [DWELL_W-1:0] dw, input logic ct,
                          input logic with_stop);
    @(posedge i_clk); #1;
    i_ch_en = en; i_dwell = dw; i_cont = ct; i_start = 1'b1; i_stop = with_stop;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_stop = 1'b0;
  endtask

  task automatic push_chan(input logic [1:0] s, input int n, input logic first_adv);
    for (int k = 0; k < n; k++) exp_q.push_back(rec(1'b1, 1'b1, s, (k == 0) && first_adv, 1'b0));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge i_clk);
    repeat (4) @(posedge i_clk);
    #1;
    chk(name, 8'(exp_q.size()), 8'd0);
    exp_q.delete();
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_hold = 1'b0;
    i_cont = 1'b0; i_ch_en = 4'd0; i_dwell = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("rst_sel", 8'(o_sel), 8'd0);
    chk("rst_valid", 8'(o_valid), 8'd0);
    chk("rst_busy", 8'(o_busy), 8'd0);
    chk("rst_ch_adv", 8'(o_ch_adv), 8'd0);
    chk("rst_done", 8'(o_done), 8'd0);
    chk("rst_state", 8'(o_dbg_state), 8'd0);

    // Empty mask: one done pulse. start together with stop: no effect.
    exp_q.push_back(rec(1'b0, 1'b0, 2'd0, 1'b0, 1'b1));
    do_start(4'b0000, 8'd2, 1'b0, 1'b0);
    drain("empty_mask");
    do_start(4'b0101, 8'd1, 1'b0, 1'b1);
    drain("start_with_stop");
    chk("start_with_stop_state", 8'(o_dbg_state), 8'd0);

    // Full mask, dwell=2, single pass. Changes to the inputs during the scan must be ignored.
    for (int c = 0; c < 4; c++) push_chan(2'(c), 3, c != 0);
    exp_q.push_back(rec(1'b0, 1'b0, 2'd3, 1'b0, 1'b1));
    do_start(4'b1111, 8'd2, 1'b0, 1'b0);
    i_dwell = 8'd9; i_cont = 1'b1; i_ch_en = 4'b0001;
    drain("full_pass");

    // Mask 1010, dwell=0, continuous, stop sampled after the 5th valid cycle.
    push_chan(2'd1, 1, 1'b0);
    push_chan(2'd3, 1, 1'b1);
    push_chan(2'd1, 1, 1'b1);
    push_chan(2'd3, 1, 1'b1);
    push_chan(2'd1, 1, 1'b1);
    exp_q.push_back(rec(1'b0, 1'b0, 2'd1, 1'b0, 1'b1));
    do_start(4'b1010, 8'd0, 1'b1, 1'b0);
    i_cont = 1'b0; i_ch_en = 4'b1111;
    i_start = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_stop = 1'b1;
    @(posedge i_clk); #1;
    i_stop = 1'b0;
    drain("cont_stop");

    // Single channel 2, dwell=3, single pass.
    push_chan(2'd2, 4, 1'b0);
    exp_q.push_back(rec(1'b0, 1'b0, 2'd2, 1'b0, 1'b1));
    do_start(4'b0100, 8'd3, 1'b0, 1'b0);
    drain("single_chan");

    // Single channel 0, continuous: ch_adv pulses on each reload while sel stays 0.
    push_chan(2'd0, 2, 1'b0);
    push_chan(2'd0, 2, 1'b1);
    push_chan(2'd0, 1, 1'b1);
    exp_q.push_back(rec(1'b0, 1'b0, 2'd0, 1'b0, 1'b1));
    do_start(4'b0001, 8'd1, 1'b1, 1'b0);
    repeat (4) @(posedge i_clk);
    #1;
    i_stop = 1'b1;
    @(posedge i_clk); #1;
    i_stop = 1'b0;
    drain("single_cont");

    // Reset in the middle of a scan: outputs return to reset values and no done pulse follows.
    push_chan(2'd2, 2, 1'b0);
    do_start(4'b0100, 8'd3, 1'b0, 1'b0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("midrst_valid", 8'(o_valid), 8'd0);
    chk("midrst_busy", 8'(o_busy), 8'd0);
    chk("midrst_sel", 8'(o_sel), 8'd0);
    chk("midrst_state", 8'(o_dbg_state), 8'd0);
    drain("midrst_no_done");

`ifdef SCAN_HOLD_EN
    // Hold for 5 cycles on channel 0: sel=0 for 7 cycles, then sel=1 for 2 cycles, then done.
    push_chan(2'd0, 7, 1'b0);
    push_chan(2'd1, 2, 1'b1);
    exp_q.push_back(rec(1'b0, 1'b0, 2'd1, 1'b0, 1'b1));
    do_start(4'b0011, 8'd1, 1'b0, 1'b0);
    i_hold = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    i_hold = 1'b0;
    drain("hold");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
